uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 108 ++++++++++
 tb/tb_uart_rx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO sitting behind a UART receiver.
// Captures one byte per rising edge of the receiver's byte-complete flag.
// Presents the head byte combinationally to the CPU and raises a sticky
// overrun flag when a byte arrives with no room left for it.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_end_flag,
    input  logic          rd_en,
    input  logic          clr_ovr,
    input  logic          irq_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          ovr,
    output logic          irq
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          end_d;
    logic          wr_req;
    logic          rd_ok;
    logic          wr_ok;
    logic          ovr_set;

    // The receiver flag may stay high for several cycles, so only its rising edge counts.
    // A full FIFO can still accept a byte when a read frees a slot on the same edge.
    // A read against an empty FIFO is ignored, so a write on that edge goes in alone.
    always_comb begin
        wr_req  = rx_end_flag & ~end_d;
        rd_ok   = rd_en & ~empty;
        wr_ok   = wr_req & (~full | rd_ok);
        ovr_set = wr_req & full & ~rd_ok;
    end

    // Remember the previous flag level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            end_d <= 1'b0;
        end else begin
            end_d <= rx_end_flag;
        end
    end

    // Storage is deliberately left out of reset; stale bytes are never visible.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy only changes when exactly one of push/pop happens.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overrun; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr <= 1'b0;
        end else if (ovr_set) begin
            ovr <= 1'b1;
        end else if (clr_ovr) begin
            ovr <= 1'b0;
        end
    end

    // Status, head byte and interrupt are all decoded from registered state.
    always_comb begin
        empty   = (count == '0);
        full    = (count == DEPTH_C);
        rd_data = empty ? 8'h00 : mem[rd_ptr];
        irq     = irq_en & (~empty | ovr);
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo.
// Stimulus pushes the bytes it expects to read back into a scoreboard queue.
// A separate monitor pops and compares whenever a read of a non-empty FIFO is presented.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_end_flag;
    logic       rd_en;
    logic       clr_ovr;
    logic       irq_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       ovr;
    logic       irq;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];

    uart_rx_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_end_flag (rx_end_flag),
        .rd_en       (rd_en),
        .clr_ovr     (clr_ovr),
        .irq_en      (irq_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .ovr         (ovr),
        .irq         (irq)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One operation edge followed by one idle edge so the next flag pulse is a fresh rising edge.
    task automatic apply_stimulus(input logic wr, input logic [7:0] data,
                                  input logic rd, input logic clr);
        rx_end_flag = wr;
        rx_data     = data;
        rd_en       = rd;
        clr_ovr     = clr;
        @(posedge clk); #1;
        rx_end_flag = 1'b0;
        rd_en       = 1'b0;
        clr_ovr     = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_write(input logic [7:0] data);
        sb.push_back(data);
        apply_stimulus(1'b1, data, 1'b0, 1'b0);
    endtask

    // Monitor: a read of a non-empty FIFO must present the oldest expected byte.
    always @(negedge clk) begin
        if (reset_n && rd_en && !empty) begin
            if (sb.size() == 0) begin
                check_output("sb_underflow", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
                check_output("rd_data", 32'(rd_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        rx_data     = 8'h00;
        rx_end_flag = 1'b0;
        rd_en       = 1'b0;
        clr_ovr     = 1'b0;
        irq_en      = 1'b1;

        // Reset state while reset is held
        #12;
        check_output("rst_count", 32'(count), 0);
        check_output("rst_empty", 32'(empty), 1);
        check_output("rst_full",  32'(full), 0);
        check_output("rst_rdata", 32'(rd_data), 0);
        check_output("rst_ovr",   32'(ovr), 0);
        check_output("rst_irq",   32'(irq), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single byte in and out
        push_write(8'hA5);
        check_output("single_count", 32'(count), 1);
        check_output("single_empty", 32'(empty), 0);
        check_output("single_head",  32'(rd_data), 32'hA5);
        check_output("single_irq",   32'(irq), 1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("single_empty2", 32'(empty), 1);
        check_output("single_rdata0", 32'(rd_data), 0);
        check_output("single_irq0",   32'(irq), 0);

        // Level flag held for 5 cycles writes only once
        sb.push_back(8'h3C);
        rx_data     = 8'h3C;
        rx_end_flag = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rx_end_flag = 1'b0;
        @(posedge clk); #1;
        check_output("level_count", 32'(count), 1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("level_empty", 32'(count), 0);

        // Fill, overrun, drain, clear
        for (int i = 1; i <= 8; i++) push_write(8'(i));
        check_output("fill_full",  32'(full), 1);
        check_output("fill_count", 32'(count), 8);
        apply_stimulus(1'b1, 8'h09, 1'b0, 1'b0);
        check_output("ovr_set",   32'(ovr), 1);
        check_output("ovr_count", 32'(count), 8);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("drain_empty", 32'(empty), 1);
        check_output("drain_irq",   32'(irq), 1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check_output("ovr_clr", 32'(ovr), 0);

        // Full with simultaneous write and read
        for (int i = 0; i < 8; i++) push_write(8'(8'h10 + i));
        sb.push_back(8'h18);
        apply_stimulus(1'b1, 8'h18, 1'b1, 1'b0);
        check_output("simul_count", 32'(count), 8);
        check_output("simul_ovr",   32'(ovr), 0);
        check_output("simul_head",  32'(rd_data), 32'h11);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("simul_drain", 32'(empty), 1);

        // Write and read together while empty: write only
        sb.push_back(8'h55);
        apply_stimulus(1'b1, 8'h55, 1'b1, 1'b0);
        check_output("wr_rd_empty_count", 32'(count), 1);
        check_output("wr_rd_empty_head",  32'(rd_data), 32'h55);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Interleaved traffic crossing the pointer wrap
        for (int i = 0; i < 20; i++) begin
            push_write(8'(8'h40 + i));
            apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_output("wrap_count", 32'(count), 0);

        // Read while empty does nothing
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("rd_empty_count", 32'(count), 0);
        check_output("rd_empty_ovr",   32'(ovr), 0);

        // Overrun together with clear keeps ovr set
        for (int i = 0; i < 8; i++) push_write(8'(8'h60 + i));
        apply_stimulus(1'b1, 8'h99, 1'b0, 1'b1);
        check_output("set_wins_ovr", 32'(ovr), 1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check_output("clr_after", 32'(ovr), 0);

        // Reset with five entries buffered
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("pre_rst_count", 32'(count), 5);
        #3;
        reset_n = 1'b0;
        sb.delete();
        #2;
        check_output("mid_rst_count", 32'(count), 0);
        check_output("mid_rst_empty", 32'(empty), 1);
        check_output("mid_rst_rdata", 32'(rd_data), 0);

        // Flag already high when reset releases counts as a new byte
        rx_data     = 8'h7E;
        rx_end_flag = 1'b1;
        @(posedge clk); #1;
        sb.push_back(8'h7E);
        reset_n = 1'b1;
        @(posedge clk); #1;
        rx_end_flag = 1'b0;
        check_output("rel_count", 32'(count), 1);
        check_output("rel_head",  32'(rd_data), 32'h7E);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

        check_output("sb_left", 32'(sb.size()), 0);
        check_output("end_empty", 32'(empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
